// File: rtl/bus_bridge_mc.sv
// Multi-channel request/ready bridge from the miniRV data port to NCH slave channels.
// Optional feature macro: BRIDGE_TIMEOUT_EN (aborts a stalled slave access with an error completion).
module bus_bridge_mc #(
  parameter int          NCH         = 6,
  parameter int          DW          = 32,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_F000,
  parameter int          IO_SEL_LSB  = 4,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [DW-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [31:0]       cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [NCH-1:0]    s_req,
  output logic              s_wen,
  output logic [31:0]       s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic [NCH*DW-1:0] s_rdata,
  input  logic [NCH-1:0]    s_ack,
  output logic [7:0]        err_cnt
);

  if (NCH < 2 || NCH > 16) begin : g_bad_nch
    $error("bus_bridge_mc: NCH out of range 2..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("bus_bridge_mc: TIMEOUT_CYC out of range 1..65535");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;

  logic [NCH-1:0] dec_onehot;
  logic           dec_hit;
  logic [NCH-1:0] ack_sel;
  logic [DW-1:0]  ack_data;

  // Address decode straight from the CPU port; only consulted in IDLE.
  always_comb begin
    dec_onehot = '0;
    dec_hit    = 1'b0;
    if (cpu_addr < IO_BASE) begin
      dec_onehot[0] = 1'b1;
      dec_hit       = 1'b1;
    end else begin
      for (int k = 1; k < NCH; k++) begin
        if (32'(cpu_addr[11:IO_SEL_LSB]) == 32'(k - 1)) begin
          dec_onehot[k] = 1'b1;
          dec_hit       = 1'b1;
        end
      end
    end
  end

  // The live s_req bit doubles as the channel select for ack and read data.
  assign ack_sel = s_ack & s_req;

  always_comb begin
    ack_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (s_req[k]) ack_data = ack_data | s_rdata[k*DW +: DW];
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tcnt;
`endif

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state     <= IDLE;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      s_req     <= '0;
      s_wen     <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      err_cnt   <= '0;
`ifdef BRIDGE_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            s_wen   <= cpu_wen;
            s_addr  <= cpu_addr;
            s_wdata <= cpu_wdata;
            if (dec_hit) begin
              s_req <= dec_onehot;
              state <= WAIT;
`ifdef BRIDGE_TIMEOUT_EN
              tcnt  <= '0;
`endif
            end else begin
              cpu_err   <= 1'b1;
              cpu_rdata <= ERR_DATA;
              cpu_ready <= 1'b1;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          // An ack on the expiry edge still completes normally.
          if (|ack_sel) begin
            cpu_rdata <= ack_data;
            cpu_err   <= 1'b0;
            cpu_ready <= 1'b1;
            s_req     <= '0;
            state     <= RESP;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (tcnt == TMO_LAST) begin
            cpu_rdata <= ERR_DATA;
            cpu_err   <= 1'b1;
            cpu_ready <= 1'b1;
            s_req     <= '0;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
`endif
        end
        RESP: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          if (cpu_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_bridge_mc.sv
// Directed bench for bus_bridge_mc (NCH=6, TIMEOUT_CYC=4); covers both BRIDGE_TIMEOUT_EN builds.
module tb_bus_bridge_mc;

  localparam int NCH = 6;
  localparam int DW  = 32;

  logic              cpu_clk = 1'b0;
  logic              cpu_rst;
  logic              cpu_req;
  logic              cpu_wen;
  logic [31:0]       cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic [DW-1:0]     cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic [NCH-1:0]    s_req;
  logic              s_wen;
  logic [31:0]       s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NCH*DW-1:0] s_rdata;
  logic [NCH-1:0]    s_ack;
  logic [7:0]        err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  bus_bridge_mc #(
    .NCH(NCH), .DW(DW), .IO_BASE(32'hFFFF_F000), .IO_SEL_LSB(4),
    .TIMEOUT_CYC(4), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .cpu_req(cpu_req), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .s_req(s_req), .s_wen(s_wen),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
    .err_cnt(err_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [31:0] v);
    s_rdata[k*DW +: DW] = v;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req   = 1'b1;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wd;
    step();
    cpu_req   = 1'b0;
  endtask

  initial begin
    cpu_rst = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    s_rdata = '0; s_ack = '0;
    step(); step();

    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_err",   32'(cpu_err),   32'd0);
    chk("rst_rdata", cpu_rdata,      32'd0);
    chk("rst_sreq",  32'(s_req),     32'd0);
    chk("rst_swen",  32'(s_wen),     32'd0);
    chk("rst_saddr", s_addr,         32'd0);
    chk("rst_swd",   s_wdata,        32'd0);
    chk("rst_ecnt",  32'(err_cnt),   32'd0);
    cpu_rst = 1'b0;
    step();

    // Zero-wait read on channel 0.
    issue(1'b0, 32'h0000_0100, 32'h0);
    chk("rd0_sreq",  32'(s_req),     32'h01);
    chk("rd0_rdy0",  32'(cpu_ready), 32'd0);
    set_rd(0, 32'h1234_5678); s_ack = 6'b000001;
    step();
    s_ack = '0;
    chk("rd0_rdy",   32'(cpu_ready), 32'd1);
    chk("rd0_data",  cpu_rdata,      32'h1234_5678);
    chk("rd0_err",   32'(cpu_err),   32'd0);
    chk("rd0_sreqc", 32'(s_req),     32'd0);
    step();
    chk("rd0_rdyoff", 32'(cpu_ready), 32'd0);

    // Write to channel 2 with three wait cycles.
    issue(1'b1, 32'hFFFF_F010, 32'h0000_00A5);
    chk("wr2_sreq",  32'(s_req),   32'h04);
    chk("wr2_swen",  32'(s_wen),   32'd1);
    chk("wr2_saddr", s_addr,       32'hFFFF_F010);
    chk("wr2_swd",   s_wdata,      32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wr2_hold_sreq", 32'(s_req),     32'h04);
      chk("wr2_hold_rdy",  32'(cpu_ready), 32'd0);
      chk("wr2_hold_addr", s_addr,         32'hFFFF_F010);
    end
    set_rd(2, 32'h0BAD_0002); s_ack = 6'b000100;
    step();
    s_ack = '0;
    chk("wr2_rdy",  32'(cpu_ready), 32'd1);
    chk("wr2_err",  32'(cpu_err),   32'd0);
    chk("wr2_data", cpu_rdata,      32'h0BAD_0002);
    step();

    // Unmapped I/O address.
    issue(1'b0, 32'hFFFF_F0F0, 32'h0);
    chk("um_sreq",  32'(s_req),     32'd0);
    chk("um_rdy",   32'(cpu_ready), 32'd1);
    chk("um_err",   32'(cpu_err),   32'd1);
    chk("um_data",  cpu_rdata,      32'hDEAD_BEEF);
    step();
    chk("um_rdyoff", 32'(cpu_ready), 32'd0);
    chk("um_ecnt",   32'(err_cnt),   32'd1);

    // Ack on channel 1 while channel 4 is selected is ignored.
    issue(1'b0, 32'hFFFF_F030, 32'h0);
    chk("x4_sreq", 32'(s_req), 32'h10);
    set_rd(1, 32'h1111_1111); set_rd(4, 32'h4444_4444); s_ack = 6'b000010;
    step();
    chk("x4_ign_rdy",  32'(cpu_ready), 32'd0);
    chk("x4_ign_sreq", 32'(s_req),     32'h10);
    step();
    chk("x4_ign_rdy2", 32'(cpu_ready), 32'd0);
    s_ack = 6'b010000;
    step();
    s_ack = '0;
    chk("x4_rdy",  32'(cpu_ready), 32'd1);
    chk("x4_data", cpu_rdata,      32'h4444_4444);
    chk("x4_err",  32'(cpu_err),   32'd0);
    step();

    // Reset during WAIT, then a normal transaction.
    issue(1'b0, 32'hFFFF_F020, 32'h0);
    chk("rw_sreq", 32'(s_req), 32'h08);
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
    chk("rw_sreq0", 32'(s_req),     32'd0);
    chk("rw_rdy0",  32'(cpu_ready), 32'd0);
    chk("rw_ecnt0", 32'(err_cnt),   32'd0);
    issue(1'b0, 32'hFFFF_F000, 32'h0);
    chk("rw_new_sreq", 32'(s_req), 32'h02);
    s_ack = 6'b000010;
    step();
    s_ack = '0;
    chk("rw_new_rdy",  32'(cpu_ready), 32'd1);
    chk("rw_new_data", cpu_rdata,      32'h1111_1111);
    step();

`ifdef BRIDGE_TIMEOUT_EN
    // Channel 3 never acks: abort after four wait cycles.
    issue(1'b0, 32'hFFFF_F020, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_hold_sreq", 32'(s_req),     32'h08);
      chk("to_hold_rdy",  32'(cpu_ready), 32'd0);
    end
    step();
    chk("to_sreq", 32'(s_req),     32'd0);
    chk("to_rdy",  32'(cpu_ready), 32'd1);
    chk("to_err",  32'(cpu_err),   32'd1);
    chk("to_data", cpu_rdata,      32'hDEAD_BEEF);
    step();
    chk("to_ecnt", 32'(err_cnt), 32'd1);
    // Ack lands on the expiry edge: normal completion wins.
    set_rd(3, 32'h3333_3333);
    issue(1'b0, 32'hFFFF_F020, 32'h0);
    step(); step(); step();
    s_ack = 6'b001000;
    step();
    s_ack = '0;
    chk("toa_rdy",  32'(cpu_ready), 32'd1);
    chk("toa_err",  32'(cpu_err),   32'd0);
    chk("toa_data", cpu_rdata,      32'h3333_3333);
    step();
    chk("toa_ecnt", 32'(err_cnt), 32'd1);
`else
    // Without the timeout, WAIT holds indefinitely.
    set_rd(3, 32'h3333_3333);
    issue(1'b0, 32'hFFFF_F020, 32'h0);
    for (int i = 0; i < 20; i++) step();
    chk("nt_hold_sreq", 32'(s_req),     32'h08);
    chk("nt_hold_rdy",  32'(cpu_ready), 32'd0);
    s_ack = 6'b001000;
    step();
    s_ack = '0;
    chk("nt_rdy",  32'(cpu_ready), 32'd1);
    chk("nt_err",  32'(cpu_err),   32'd0);
    chk("nt_data", cpu_rdata,      32'h3333_3333);
    step();
    chk("nt_ecnt", 32'(err_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
